// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: states, opcodes,
// ALU/extender codes and datapath mux selects.
package rv_ctrl_pkg;

   typedef enum logic [4:0] {
      S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JLINK,
      S_LUI, S_AUIPC, S_ILLEGAL, S_TRAP
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   localparam logic [2:0] EXT_I = 3'b000;
   localparam logic [2:0] EXT_S = 3'b001;
   localparam logic [2:0] EXT_B = 3'b010;
   localparam logic [2:0] EXT_U = 3'b011;
   localparam logic [2:0] EXT_J = 3'b100;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/rv_alu_dec.sv
// ALU function decoder: maps the FSM's coarse alu_op plus funct fields to alu_ctrl.
module rv_alu_dec
   import rv_ctrl_pkg::*;
(
   input  alu_op_t    alu_op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       is_rtype_i,
   output logic [3:0] alu_ctrl_o
);

   // funct7b5 selects SUB only for register ops; for immediates it is imm[10]
   always_comb begin
      alu_ctrl_o = ALU_ADD;
      case (alu_op_i)
         ALUOP_ADD: alu_ctrl_o = ALU_ADD;
         ALUOP_SUB: alu_ctrl_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               3'b000: begin
                  if (is_rtype_i && funct7b5_i) alu_ctrl_o = ALU_SUB;
                  else                          alu_ctrl_o = ALU_ADD;
               end
               3'b001: alu_ctrl_o = ALU_SLL;
               3'b010: alu_ctrl_o = ALU_SLT;
               3'b011: alu_ctrl_o = ALU_SLTU;
               3'b100: alu_ctrl_o = ALU_XOR;
               3'b101: begin
                  if (funct7b5_i) alu_ctrl_o = ALU_SRA;
                  else            alu_ctrl_o = ALU_SRL;
               end
               3'b110: alu_ctrl_o = ALU_OR;
               3'b111: alu_ctrl_o = ALU_AND;
               default: alu_ctrl_o = ALU_ADD;
            endcase
         end
         default: alu_ctrl_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core. Define RV_CTRL_ILLEGAL_TRAP_EN
// to make illegal opcodes halt in a sticky TRAP state instead of acting as NOPs.
module rv_multicycle_ctrl
   import rv_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [3:0] alu_ctrl,
   output logic [2:0] extend_ctrl,
   output logic       trap
);

   state_t  state_q, state_d;
   alu_op_t alu_op_s;

   // State register; IDLE decodes to all-zero outputs so reset silences the bus at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state and state-decoded datapath controls
   always_comb begin
      state_d     = state_q;
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RS2;
      result_src  = RES_ALUOUT;
      alu_op_s    = ALUOP_ADD;
      extend_ctrl = EXT_I;
      trap        = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            if (mem_ready) state_d = S_DECODE;
            else           state_d = S_FETCH;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            if (opcode == OP_JAL) extend_ctrl = EXT_J;
            else                  extend_ctrl = EXT_B;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_AUIPC;
               default:           state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            if (opcode == OP_STORE) begin
               extend_ctrl = EXT_S;
               state_d     = S_MEMWRITE;
            end else begin
               extend_ctrl = EXT_I;
               state_d     = S_MEMREAD;
            end
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
            else           state_d = S_MEMREAD;
         end
         S_MEMWB: begin
            result_src = RES_MEM;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 1'b1;
            if (mem_ready) state_d = S_FETCH;
            else           state_d = S_MEMWRITE;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            alu_op_s  = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op_s  = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            // BEQ/BNE only; other funct3 values fall through as not-taken
            alu_src_a = SRCA_RS1;
            alu_op_s  = ALUOP_SUB;
            if (funct3[2:1] == 2'b00) pc_write = zero ^ funct3[0];
            else                      pc_write = 1'b0;
            state_d   = S_FETCH;
         end
         S_JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_write  = 1'b1;
            state_d   = S_ALUWB;
         end
         S_JALR: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            result_src = RES_ALU;
            pc_write   = 1'b1;
            state_d    = S_JLINK;
         end
         S_JLINK: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            state_d   = S_ALUWB;
         end
         S_LUI: begin
            alu_src_a   = SRCA_ZERO;
            alu_src_b   = SRCB_IMM;
            extend_ctrl = EXT_U;
            state_d     = S_ALUWB;
         end
         S_AUIPC: begin
            alu_src_a   = SRCA_OLDPC;
            alu_src_b   = SRCB_IMM;
            extend_ctrl = EXT_U;
            state_d     = S_ALUWB;
         end
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
         S_ILLEGAL: state_d = S_TRAP;
         S_TRAP: begin
            trap    = 1'b1;
            state_d = S_TRAP;
         end
`else
         S_ILLEGAL: state_d = S_FETCH;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   rv_alu_dec u_alu_dec (
      .alu_op_i   (alu_op_s),
      .funct3_i   (funct3),
      .funct7b5_i (funct7b5),
      .is_rtype_i (opcode == OP_RTYPE),
      .alu_ctrl_o (alu_ctrl)
   );

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl: directed instructions, a reset
// in the middle of a memory read, then random instructions with random memory latency.
module tb_rv_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5, zero, mem_ready;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, trap;
   logic [1:0] alu_src_a, alu_src_b, result_src;
   logic [3:0] alu_ctrl;
   logic [2:0] extend_ctrl;

   always #5 clk = ~clk;

   rv_multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
      .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
      .alu_ctrl(alu_ctrl), .extend_ctrl(extend_ctrl), .trap(trap)
   );

   typedef struct packed {
      logic       req, wr, adr, irw, pcw, rw;
      logic [1:0] a, b, res;
      logic [3:0] alu;
      logic [2:0] ext;
      logic       trp;
   } outs_t;

   // mem = 1: the step repeats until mem_ready, and ir/pc strobes follow mem_ready
   typedef struct packed {
      outs_t o;
      logic  mem;
   } step_t;

   step_t      plan[$];
   int         vectors = 0;
   int         miscompares = 0;
   logic [6:0] cur_op;
   logic [2:0] cur_f3;
   logic       cur_f7, cur_z;

   function automatic outs_t mk(input logic req, wr, adr, irw, pcw, rw,
                                input logic [1:0] a, b, res, input logic [3:0] alu,
                                input logic [2:0] ext, input logic trp);
      outs_t r;
      r = {req, wr, adr, irw, pcw, rw, a, b, res, alu, ext, trp};
      return r;
   endfunction

   function automatic outs_t observed();
      outs_t r;
      r = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, alu_ctrl, extend_ctrl, trap};
      return r;
   endfunction

   // RV32I operation named by funct3/funct7 -> alu_ctrl code
   function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic f7, input logic is_r);
      case (f3)
         3'd0: return (is_r && f7) ? 4'd1 : 4'd0;
         3'd1: return 4'd7;
         3'd2: return 4'd5;
         3'd3: return 4'd6;
         3'd4: return 4'd4;
         3'd5: return f7 ? 4'd9 : 4'd8;
         3'd6: return 4'd3;
         default: return 4'd2;
      endcase
   endfunction

   task automatic check(input string tag, input outs_t exp);
      outs_t obs;
      obs = observed();
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected per-cycle control outputs of one instruction, FETCH onward
   task automatic build();
      outs_t wb, idle;
      logic  taken;
      wb   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd0,2'd0,2'd0, 4'd0, 3'd0, 1'b0);
      idle = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd0, 4'd0, 3'd0, 1'b0);
      plan.delete();
      plan.push_back('{mk(1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 2'd0,2'd2,2'd2, 4'd0, 3'd0, 1'b0), 1'b1});
      plan.push_back('{mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd1,2'd1,2'd0, 4'd0,
                          (cur_op == 7'b1101111) ? 3'd4 : 3'd2, 1'b0), 1'b0});
      case (cur_op)
         7'b0000011: begin
            plan.push_back('{mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd1,2'd0, 4'd0, 3'd0, 1'b0), 1'b0});
            plan.push_back('{mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd0, 4'd0, 3'd0, 1'b0), 1'b1});
            plan.push_back('{mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 2'd0,2'd0,2'd1, 4'd0, 3'd0, 1'b0), 1'b0});
         end
         7'b0100011: begin
            plan.push_back('{mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd1,2'd0, 4'd0, 3'd1, 1'b0), 1'b0});
            plan.push_back('{mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd0, 4'd0, 3'd0, 1'b0), 1'b1});
         end
         7'b0110011: begin
            plan.push_back('{mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd0,2'd0,
                                alu_ref(cur_f3, cur_f7, 1'b1), 3'd0, 1'b0), 1'b0});
            plan.push_back('{wb, 1'b0});
         end
         7'b0010011: begin
            plan.push_back('{mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd1,2'd0,
                                alu_ref(cur_f3, cur_f7, 1'b0), 3'd0, 1'b0), 1'b0});
            plan.push_back('{wb, 1'b0});
         end
         7'b1100011: begin
            taken = ((cur_f3 == 3'd0) && cur_z) || ((cur_f3 == 3'd1) && !cur_z);
            plan.push_back('{mk(1'b0,1'b0,1'b0,1'b0,taken,1'b0, 2'd2,2'd0,2'd0, 4'd1, 3'd0, 1'b0), 1'b0});
         end
         7'b1101111: begin
            plan.push_back('{mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'd1,2'd2,2'd0, 4'd0, 3'd0, 1'b0), 1'b0});
            plan.push_back('{wb, 1'b0});
         end
         7'b1100111: begin
            plan.push_back('{mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 2'd2,2'd1,2'd2, 4'd0, 3'd0, 1'b0), 1'b0});
            plan.push_back('{mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd1,2'd2,2'd0, 4'd0, 3'd0, 1'b0), 1'b0});
            plan.push_back('{wb, 1'b0});
         end
         7'b0110111: begin
            plan.push_back('{mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd3,2'd1,2'd0, 4'd0, 3'd3, 1'b0), 1'b0});
            plan.push_back('{wb, 1'b0});
         end
         7'b0010111: begin
            plan.push_back('{mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd1,2'd1,2'd0, 4'd0, 3'd3, 1'b0), 1'b0});
            plan.push_back('{wb, 1'b0});
         end
         default: plan.push_back('{idle, 1'b0});
      endcase
   endtask

   // delay < 0: random memory latency; otherwise exactly `delay` not-ready cycles per access
   task automatic run_plan(input int delay, input int stop_at);
      int    waits;
      bit    done;
      outs_t exp;
      for (int i = 0; i < plan.size(); i++) begin
         if (stop_at >= 0 && i >= stop_at) break;
         waits = 0;
         done  = 1'b0;
         while (!done) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
               opcode = cur_op; funct3 = cur_f3; funct7b5 = cur_f7; zero = cur_z;
            end
            if (plan[i].mem) begin
               if (delay < 0) mem_ready = (waits >= 6) || ($urandom_range(0, 2) == 0);
               else           mem_ready = (waits >= delay);
            end else begin
               mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            exp = plan[i].o;
            if (plan[i].mem) begin
               exp.irw = exp.irw & mem_ready;
               exp.pcw = exp.pcw & mem_ready;
            end
            check($sformatf("op%b_f3%0d_step%0d", cur_op, cur_f3, i), exp);
            done = !plan[i].mem || mem_ready;
            waits++;
         end
      end
   endtask

   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic z, input int delay);
      cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z;
      build();
      run_plan(delay, -1);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("idle_after_reset", '0);
   endtask

   initial begin
      logic [6:0] rop;
      int         k;
      rst_n = 1'b0; opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
      #2;
      check("reset_outputs", '0);
      release_reset();

      run_instr(7'b0010011, 3'd0, 1'b0, 1'b0, 0);   // ADDI
      run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 3);   // LW, slow memory
      run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 1);   // SW
      run_instr(7'b1100011, 3'd0, 1'b0, 1'b1, 0);   // BEQ taken
      run_instr(7'b1100011, 3'd1, 1'b0, 1'b1, 0);   // BNE not taken
      run_instr(7'b1100011, 3'd4, 1'b0, 1'b1, 0);   // BLT treated as not taken
      run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, 0);   // JAL
      run_instr(7'b1100111, 3'd0, 1'b0, 1'b0, 0);   // JALR
      run_instr(7'b0110111, 3'd0, 1'b0, 1'b0, 0);   // LUI
      run_instr(7'b0010111, 3'd0, 1'b0, 1'b0, 0);   // AUIPC
      run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 0);   // SUB
      run_instr(7'b0010011, 3'd5, 1'b1, 1'b0, 0);   // SRAI
      run_instr(7'b0010011, 3'd0, 1'b1, 1'b0, 0);   // ADDI with imm[10] set stays ADD

      // reset asserted while a load is waiting on memory
      cur_op = 7'b0000011; cur_f3 = 3'd2; cur_f7 = 1'b0; cur_z = 1'b0;
      build();
      run_plan(0, 3);
      @(posedge clk);
      #1 mem_ready = 1'b0;
      #1 check("memread_before_reset", plan[3].o);
      rst_n = 1'b0;
      #1 check("reset_mid_access", '0);
      @(posedge clk);
      #1 check("reset_held", '0);
      release_reset();

      for (int n = 0; n < 150; n++) begin
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
         k = $urandom_range(0, 8);
`else
         k = $urandom_range(0, 9);
`endif
         case (k)
            0: rop = 7'b0000011;
            1: rop = 7'b0100011;
            2: rop = 7'b0110011;
            3: rop = 7'b0010011;
            4: rop = 7'b1100011;
            5: rop = 7'b1101111;
            6: rop = 7'b1100111;
            7: rop = 7'b0110111;
            8: rop = 7'b0010111;
            default: rop = ($urandom_range(0, 1) == 0) ? 7'b0001111 : 7'b1110011;
         endcase
         run_instr(rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), -1);
      end

      run_instr(7'b0000000, 3'd0, 1'b0, 1'b0, 0);
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
      for (int c = 0; c < 22; c++) begin
         @(posedge clk);
         #1 mem_ready = 1'($urandom_range(0, 1));
         #1 check($sformatf("trap_hold%0d", c),
                  mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,2'd0, 4'd0, 3'd0, 1'b1));
      end
`else
      run_instr(7'b0010011, 3'd0, 1'b0, 1'b0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
